trig_capture_ctrl: RTL and testbench
====================================

// Module: trig_capture_ctrl
// PURPOSE
//  N-channel trigger and capture-window controller for the logic analyzer. Takes the
//  per-channel High/Low comparator bits already registered in the clk domain by the
//  sampler_reg stage, evaluates a per-channel trigger condition, ANDs the channels, and
//  sequences capture: pre-trigger fill, armed, post-trigger count, done. Generalises the
//  fixed 5-channel trigger path to NUM_CH channels with trigger-position control.
// PARAMETERS
//  NUM_CH  5     number of channels
//  DEPTH   384   capture buffer depth in samples
//  CNT_W   $clog2(DEPTH)+1  sample counter / trig_pos width (derived, do not override)
// PORTS
//  clk        in   1            system clock; the only clock
//  rst_n      in   1            asynchronous active-low reset
//  wrt_smpl   in   1            one-cycle strobe: a sample is written to the buffer this cycle
//  chh        in   NUM_CH       per-channel High comparator bit (clk domain)
//  chl        in   NUM_CH       per-channel Low comparator bit (clk domain)
//  trig_cfg   in   NUM_CH*5     5 cfg bits per channel, ch i at [5i+4:5i]
//  trig_pos   in   CNT_W        post-trigger sample count; values > DEPTH saturate to DEPTH
//  arm        in   1            pulse: start a capture
//  clr        in   1            pulse: abort/acknowledge, return to IDLE
//  armed      out  1            high in ARMED state
//  triggered  out  1            high from trigger event until return to IDLE
//  capt_done  out  1            high in DONE state
//  ch_trig    out  NUM_CH       registered per-channel trigger condition
// BEHAVIOUR
//  - Reset: state IDLE; armed/triggered/capt_done/ch_trig = 0; counters = 0; history flops 0.
//  - cfg bits per channel: [4] rising edge on chh, [3] falling edge on chl, [2] chh level 1,
//    [1] chl level 0, [0] don't-care. Channel condition = [0] | OR of selected terms.
//  - Edge detect uses one history flop per signal; edges are sticky: set on edge while
//    state==ARMED, cleared whenever state!=ARMED. Edges before ARMED are ignored.
//  - Levels combinational from current chh/chl. ch_trig registered (1-cycle latency).
//  - Combined trigger = AND of ch_trig over all channels, forced 0 if every channel has
//    cfg==5'b00001 or cfg==0 selects nothing (all-don't-care never triggers).
//  - FSM (registered, 1 transition/cycle):
//    IDLE    : arm -> PRETRIG, pre_cnt<=0.
//    PRETRIG : pre_cnt++ on wrt_smpl; when pre_cnt == DEPTH-trig_pos_sat -> ARMED
//              (target 0 => ARMED next cycle).
//    ARMED   : combined trigger -> POSTTRIG, triggered<=1, post_cnt<=0.
//    POSTTRIG: post_cnt++ on wrt_smpl; when post_cnt == trig_pos_sat -> DONE
//              (trig_pos 0 => DONE next cycle).
//    DONE    : capt_done=1, held until clr.
//  - clr in any state -> IDLE next cycle, clears triggered and sticky flops; clr beats arm
//    in the same cycle. arm outside IDLE is ignored. trig_pos sampled on arm (latched),
//    later changes have no effect on the running capture.
//  - Counters never wrap: they stop at target; wrt_smpl in IDLE/ARMED/DONE ignored.
//  - Async reset mid-capture returns everything to reset values immediately.
// STRUCTURE
//  - Package la_trig_pkg: state enum {IDLE,PRETRIG,ARMED,POSTTRIG,DONE}, localparams
//    for cfg bit indices (CFG_RISE=4, CFG_FALL=3, CFG_HI=2, CFG_LO=1, CFG_DC=0).
//  - Sub-module chan_trig_cell: one channel's history flops, sticky edges, ch_trig reg;
//    instantiated NUM_CH times with generate. FSM and counters in top.
// TESTING
//  - Reset: hold rst_n=0 mid-POSTTRIG -> all outputs 0 asynchronously, state IDLE after release.
//  - Rising trig: NUM_CH=5, ch0 cfg=10000, others 00001, trig_pos=8, arm, 376 wrt_smpl ->
//    armed=1; pulse chh[0] 0->1 -> triggered=1 within 2 clk; 8 wrt_smpl -> capt_done=1.
//  - Pre-arm edge ignored: chh[0] rises during PRETRIG and stays high -> no trigger in ARMED;
//    cfg 00100 instead -> triggers 2 clk after entering ARMED.
//  - AND combine: ch1 cfg=01000, ch2 cfg=00010; fall on chl[1] alone -> no trig; then chl[2]=0
//    -> trigger (sticky edge held).
//  - Boundaries: trig_pos=0 -> DONE 1 cycle after trigger; trig_pos=500 -> ARMED next cycle after arm,
//    DONE after 384 wrt_smpl; all cfg 00001 -> never triggers.
//  - clr+arm same cycle in DONE -> IDLE, capt_done=0, no new capture started.

Source files
------------

// File: rtl/la_trig_pkg.sv
// Shared types and constants for the logic-analyzer trigger / capture controller.
//   trig_state_e : capture sequencer states
//   CFG_*        : bit positions inside one channel's 5-bit trigger config
package la_trig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POSTTRIG,
        DONE
    } trig_state_e;

    localparam int unsigned CFG_W    = 5;
    localparam int unsigned CFG_RISE = 4;  // rising edge on chh
    localparam int unsigned CFG_FALL = 3;  // falling edge on chl
    localparam int unsigned CFG_HI   = 2;  // chh level 1
    localparam int unsigned CFG_LO   = 1;  // chl level 0
    localparam int unsigned CFG_DC   = 0;  // don't care

    // A channel configured as pure don't-care.
    localparam logic [CFG_W-1:0] CFG_ALL_DC = 5'b00001;

endpackage

// File: rtl/chan_trig_cell.sv
// One channel of the trigger path: history flops for edge detection, sticky edge
// flags and the registered per-channel trigger condition.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   en_i        capture window is open (ARMED and not being cleared); when low the
//               sticky edges and the channel condition are cleared
//   chh_i       High comparator bit
//   chl_i       Low comparator bit
//   cfg_i       5-bit trigger config for this channel
//   ch_trig_o   registered channel condition
module chan_trig_cell
    import la_trig_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             chh_i,
    input  logic             chl_i,
    input  logic [CFG_W-1:0] cfg_i,
    output logic             ch_trig_o
);

    logic chh_q, chl_q;
    logic rise_stk_q, rise_stk_d;
    logic fall_stk_q, fall_stk_d;
    logic ch_trig_q, ch_trig_d;
    logic rise, fall, cond;

    always_comb begin
        rise       = chh_i & ~chh_q;
        fall       = chl_q & ~chl_i;
        // Edges latch only while the window is open, so edges seen before ARMED are lost.
        rise_stk_d = en_i & (rise_stk_q | rise);
        fall_stk_d = en_i & (fall_stk_q | fall);
        cond       = cfg_i[CFG_DC]
                   | (cfg_i[CFG_RISE] & rise_stk_d)
                   | (cfg_i[CFG_FALL] & fall_stk_d)
                   | (cfg_i[CFG_HI]   & chh_i)
                   | (cfg_i[CFG_LO]   & ~chl_i);
        ch_trig_d  = en_i & cond;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chh_q      <= 1'b0;
            chl_q      <= 1'b0;
            rise_stk_q <= 1'b0;
            fall_stk_q <= 1'b0;
            ch_trig_q  <= 1'b0;
        end else begin
            chh_q      <= chh_i;
            chl_q      <= chl_i;
            rise_stk_q <= rise_stk_d;
            fall_stk_q <= fall_stk_d;
            ch_trig_q  <= ch_trig_d;
        end
    end

    assign ch_trig_o = ch_trig_q;

endmodule

// File: rtl/trig_capture_ctrl.sv
// N-channel trigger and capture-window controller. Evaluates per-channel trigger
// conditions, ANDs them, and sequences pre-trigger fill, armed, post-trigger count, done.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   wrt_smpl    one-cycle strobe: a sample is written this cycle
//   chh, chl    per-channel High / Low comparator bits
//   trig_cfg    5 config bits per channel, channel i at [5i+4:5i]
//   trig_pos    post-trigger sample count, saturated to DEPTH, latched on arm
//   arm, clr    start a capture / abort and return to IDLE (clr wins)
//   armed       state is ARMED
//   triggered   trigger seen, held until IDLE
//   capt_done   state is DONE
//   ch_trig     registered per-channel trigger condition
module trig_capture_ctrl
    import la_trig_pkg::*;
#(
    parameter  int unsigned NUM_CH = 5,
    parameter  int unsigned DEPTH  = 384,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wrt_smpl,
    input  logic [NUM_CH-1:0]       chh,
    input  logic [NUM_CH-1:0]       chl,
    input  logic [NUM_CH*CFG_W-1:0] trig_cfg,
    input  logic [CNT_W-1:0]        trig_pos,
    input  logic                    arm,
    input  logic                    clr,
    output logic                    armed,
    output logic                    triggered,
    output logic                    capt_done,
    output logic [NUM_CH-1:0]       ch_trig
);

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

    trig_state_e      state_q, state_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0] tpos_q, tpos_d;
    logic             trig_q, trig_d;

    logic [CNT_W-1:0] tpos_sat;
    logic [CNT_W-1:0] pre_target;
    logic             all_dc;
    logic             edge_en;
    logic             comb_trig;

    assign edge_en = (state_q == ARMED) & ~clr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_trig_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (edge_en),
            .chh_i     (chh[i]),
            .chl_i     (chl[i]),
            .cfg_i     (trig_cfg[CFG_W*i +: CFG_W]),
            .ch_trig_o (ch_trig[i])
        );
    end

    always_comb begin
        all_dc = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_cfg[CFG_W*i +: CFG_W] != CFG_ALL_DC) begin
                all_dc = 1'b0;
            end
        end
    end

    // An all-don't-care configuration would fire immediately; it is defined to never fire.
    assign comb_trig  = (&ch_trig) & ~all_dc;
    assign tpos_sat   = (trig_pos > DepthC) ? DepthC : trig_pos;
    assign pre_target = DepthC - tpos_q;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        tpos_d     = tpos_q;
        trig_d     = trig_q;
        if (clr) begin
            state_d = IDLE;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d   = PRETRIG;
                        pre_cnt_d = '0;
                        tpos_d    = tpos_sat;
                    end
                end
                PRETRIG: begin
                    if (pre_cnt_q == pre_target) begin
                        state_d = ARMED;
                    end else if (wrt_smpl) begin
                        pre_cnt_d = pre_cnt_q + CNT_W'(1);
                    end
                end
                ARMED: begin
                    if (comb_trig) begin
                        state_d    = POSTTRIG;
                        trig_d     = 1'b1;
                        post_cnt_d = '0;
                    end
                end
                POSTTRIG: begin
                    if (post_cnt_q == tpos_q) begin
                        state_d = DONE;
                    end else if (wrt_smpl) begin
                        post_cnt_d = post_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            tpos_q     <= '0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            tpos_q     <= tpos_d;
            trig_q     <= trig_d;
        end
    end

    assign armed     = (state_q == ARMED);
    assign capt_done = (state_q == DONE);
    assign triggered = trig_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Self-checking bench for trig_capture_ctrl: a cycle model checked every clock,
// a table of trigger-condition vectors, directed multi-cycle sequences and random stimulus.
module tb_trig_capture_ctrl;

    localparam int NUM_CH = 5;
    localparam int DEPTH  = 384;
    localparam int CNT_W  = 10;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic                  wrt_smpl = 1'b0;
    logic                  arm      = 1'b0;
    logic                  clr      = 1'b0;
    logic [NUM_CH-1:0]     chh      = '0;
    logic [NUM_CH-1:0]     chl      = '1;
    logic [NUM_CH*5-1:0]   trig_cfg = '0;
    logic [CNT_W-1:0]      trig_pos = '0;
    logic                  armed, triggered, capt_done;
    logic [NUM_CH-1:0]     ch_trig;

    trig_capture_ctrl #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt_smpl  (wrt_smpl),
        .chh       (chh),
        .chl       (chl),
        .trig_cfg  (trig_cfg),
        .trig_pos  (trig_pos),
        .arm       (arm),
        .clr       (clr),
        .armed     (armed),
        .triggered (triggered),
        .capt_done (capt_done),
        .ch_trig   (ch_trig)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Phase: 0 idle, 1 filling pre-trigger, 2 waiting for trigger,
    // 3 filling post-trigger, 4 done. Fill phases count samples still owed down to zero.
    int                m_ph, m_left, m_tpos;
    bit                m_trig;
    bit [NUM_CH-1:0]   m_ct, m_hh, m_hl, m_rs, m_fs;

    task automatic model_reset();
        m_ph = 0; m_left = 0; m_tpos = 0; m_trig = 0;
        m_ct = '0; m_hh = '0; m_hl = '0; m_rs = '0; m_fs = '0;
    endtask

    task automatic model_step();
        bit win, alldc, fire, r, f;
        bit [NUM_CH-1:0] nct, nrs, nfs;
        logic [4:0] c;
        int tp;
        win   = (m_ph == 2) && !clr;
        alldc = 1;
        for (int i = 0; i < NUM_CH; i++) begin
            c = trig_cfg[5*i +: 5];
            if (c != 5'b00001) alldc = 0;
            r = chh[i] && !m_hh[i];
            f = m_hl[i] && !chl[i];
            nrs[i] = win && (m_rs[i] || r);
            nfs[i] = win && (m_fs[i] || f);
            nct[i] = win && (c[0] || (c[4] && nrs[i]) || (c[3] && nfs[i]) ||
                             (c[2] && chh[i]) || (c[1] && !chl[i]));
        end
        fire = (&m_ct) && !alldc;
        if (clr) begin
            m_ph = 0; m_trig = 0;
        end else begin
            case (m_ph)
                0: if (arm) begin
                    tp = (int'(trig_pos) > DEPTH) ? DEPTH : int'(trig_pos);
                    m_tpos = tp; m_left = DEPTH - tp; m_ph = 1;
                end
                1: if (m_left == 0) m_ph = 2; else if (wrt_smpl) m_left--;
                2: if (fire) begin m_ph = 3; m_trig = 1; m_left = m_tpos; end
                3: if (m_left == 0) m_ph = 4; else if (wrt_smpl) m_left--;
                default: ;
            endcase
        end
        m_ct = nct; m_rs = nrs; m_fs = nfs; m_hh = chh; m_hl = chl;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        check("mdl_armed", armed, (m_ph == 2));
        check("mdl_triggered", triggered, m_trig);
        check("mdl_capt_done", capt_done, (m_ph == 4));
        check("mdl_ch_trig", ch_trig, m_ct);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return armed;
            1:       return triggered;
            default: return capt_done;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int sel, input int budget);
        int k;
        logic v;
        k = 0;
        v = pick(sel);
        while (!v && k < budget) begin
            cycle();
            k++;
            v = pick(sel);
        end
        check(name, v, 1'b1);
    endtask

    task automatic do_clr();
        clr = 1'b1; cycle(); clr = 1'b0;
    endtask

    task automatic pulse_arm(input int tpos);
        trig_pos = CNT_W'(tpos); arm = 1'b1; cycle(); arm = 1'b0;
    endtask

    task automatic wrt_n(input int n);
        wrt_smpl = 1'b1;
        repeat (n) cycle();
        wrt_smpl = 1'b0;
    endtask

    typedef struct {
        logic [24:0]       cfg;
        logic [NUM_CH-1:0] hh0, hl0, hh1, hl1;
        logic              exp;
    } vec_t;

    vec_t vecs[9];

    localparam logic [4:0] DC = 5'b00001;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cfg {ch4,ch3,ch2,ch1,ch0}                  hh0       hl0       hh1       hl1      exp
        vecs[0] = '{{DC, DC, DC, DC, 5'b10000},             5'b00000, 5'b11111, 5'b00001, 5'b11111, 1'b1};
        vecs[1] = '{{DC, DC, DC, DC, 5'b10000},             5'b00001, 5'b11111, 5'b00001, 5'b11111, 1'b0};
        vecs[2] = '{{DC, DC, DC, DC, 5'b00100},             5'b00001, 5'b11111, 5'b00001, 5'b11111, 1'b1};
        vecs[3] = '{{DC, DC, 5'b00010, 5'b01000, DC},       5'b00000, 5'b11111, 5'b00000, 5'b11101, 1'b0};
        vecs[4] = '{{DC, DC, 5'b00010, 5'b01000, DC},       5'b00000, 5'b11111, 5'b00000, 5'b11001, 1'b1};
        vecs[5] = '{{DC, DC, DC, DC, DC},                   5'b00000, 5'b11111, 5'b11111, 5'b00000, 1'b0};
        vecs[6] = '{{DC, DC, DC, DC, 5'b00000},             5'b00000, 5'b11111, 5'b11111, 5'b00000, 1'b0};
        vecs[7] = '{{DC, 5'b00010, DC, DC, DC},             5'b00000, 5'b11111, 5'b00000, 5'b10111, 1'b1};
        vecs[8] = '{{DC, DC, DC, 5'b01000, DC},             5'b00000, 5'b11101, 5'b00000, 5'b11101, 1'b0};

        model_reset();
        #1;
        check("rst_armed", armed, 1'b0);
        check("rst_triggered", triggered, 1'b0);
        check("rst_capt_done", capt_done, 1'b0);
        check("rst_ch_trig", ch_trig, '0);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // Rising-edge trigger with trig_pos 8: 376 pre samples, 8 post samples.
        trig_cfg = {DC, DC, DC, DC, 5'b10000};
        pulse_arm(8);
        trig_pos = '0;  // latched value must stay in force
        wrt_n(376);
        check("rise_armed_not_early", armed, 1'b0);
        cycle();
        check("rise_armed", armed, 1'b1);
        chh[0] = 1'b1; cycle(); chh[0] = 1'b0;
        check("rise_trig_not_early", triggered, 1'b0);
        cycle();
        check("rise_triggered_2clk", triggered, 1'b1);
        wrt_n(8);
        check("rise_done_not_early", capt_done, 1'b0);
        cycle();
        check("rise_done", capt_done, 1'b1);
        repeat (3) cycle();
        check("done_held", capt_done, 1'b1);

        // Edge during PRETRIG is ignored, level on the same input triggers.
        do_clr();
        pulse_arm(380);
        cycle();
        chh[0] = 1'b1;
        wrt_smpl = 1'b1;
        wait_sig("prearm_armed", 0, 20);
        wrt_smpl = 1'b0;
        repeat (10) cycle();
        check("prearm_edge_ignored", triggered, 1'b0);
        do_clr();
        trig_cfg = {DC, DC, DC, DC, 5'b00100};
        pulse_arm(380);
        wrt_smpl = 1'b1;
        wait_sig("level_armed", 0, 20);
        wrt_smpl = 1'b0;
        cycle();
        check("level_trig_not_1clk", triggered, 1'b0);
        cycle();
        check("level_trig_2clk", triggered, 1'b1);

        // AND combine with a sticky falling edge.
        do_clr();
        chh = '0; chl = '1;
        trig_cfg = {DC, DC, 5'b00010, 5'b01000, DC};
        pulse_arm(384);
        wait_sig("and_armed", 0, 4);
        chl[1] = 1'b0; cycle(); chl[1] = 1'b1;
        repeat (4) cycle();
        check("and_partial_no_trig", triggered, 1'b0);
        chl[2] = 1'b0;
        cycle(); cycle();
        check("and_sticky_trig", triggered, 1'b1);
        chl = '1;

        // trig_pos 0: DONE one cycle after the trigger.
        do_clr();
        chh = 5'b00001;
        trig_cfg = {DC, DC, DC, DC, 5'b00100};
        pulse_arm(0);
        wrt_n(384);
        wait_sig("tp0_armed", 0, 3);
        wait_sig("tp0_triggered", 1, 4);
        check("tp0_done_not_early", capt_done, 1'b0);
        cycle();
        check("tp0_done", capt_done, 1'b1);

        // trig_pos 500 saturates to DEPTH.
        do_clr();
        pulse_arm(500);
        check("tp500_armed_not_early", armed, 1'b0);
        cycle();
        check("tp500_armed", armed, 1'b1);
        wait_sig("tp500_triggered", 1, 4);
        wrt_n(384);
        check("tp500_done_not_early", capt_done, 1'b0);
        cycle();
        check("tp500_done", capt_done, 1'b1);

        // clr and arm together in DONE: clr wins.
        clr = 1'b1; arm = 1'b1; trig_pos = CNT_W'(384);
        cycle();
        clr = 1'b0; arm = 1'b0;
        check("clrarm_done", capt_done, 1'b0);
        check("clrarm_triggered", triggered, 1'b0);
        repeat (4) cycle();
        check("clrarm_no_capture", armed, 1'b0);
        check("clrarm_no_trig", triggered, 1'b0);

        // Table of trigger-condition vectors.
        for (int i = 0; i < 9; i++) begin
            do_clr();
            trig_cfg = vecs[i].cfg;
            chh = vecs[i].hh0;
            chl = vecs[i].hl0;
            cycle(); cycle();
            pulse_arm(384);
            wait_sig($sformatf("vec%0d_armed", i), 0, 4);
            cycle(); cycle();
            chh = vecs[i].hh1;
            chl = vecs[i].hl1;
            repeat (4) cycle();
            check($sformatf("vec%0d_trig", i), triggered, vecs[i].exp);
        end

        // Asynchronous reset in POSTTRIG.
        do_clr();
        chh = 5'b00001; chl = '1;
        trig_cfg = {DC, DC, DC, DC, 5'b00100};
        pulse_arm(384);
        wait_sig("rst_seq_armed", 0, 4);
        wait_sig("rst_seq_triggered", 1, 4);
        wrt_n(3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_triggered", triggered, 1'b0);
        check("async_rst_armed", armed, 1'b0);
        check("async_rst_done", capt_done, 1'b0);
        check("async_rst_ch_trig", ch_trig, '0);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        check("post_rst_idle", armed | triggered | capt_done, 1'b0);

        // Random stimulus against the model.
        for (int n = 0; n < 4000; n++) begin
            if (n % 400 == 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    case ($urandom_range(0, 6))
                        0, 1:    trig_cfg[5*c +: 5] = 5'b00001;
                        2:       trig_cfg[5*c +: 5] = 5'b10000;
                        3:       trig_cfg[5*c +: 5] = 5'b01000;
                        4:       trig_cfg[5*c +: 5] = 5'b00100;
                        5:       trig_cfg[5*c +: 5] = 5'b00010;
                        default: trig_cfg[5*c +: 5] = 5'($urandom);
                    endcase
                end
            end
            arm      = ($urandom_range(0, 15) == 0);
            clr      = ($urandom_range(0, 399) == 0);
            wrt_smpl = $urandom_range(0, 1) == 1;
            trig_pos = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 1023))
                                                   : CNT_W'($urandom_range(360, 520));
            chh = chh ^ (NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom));
            chl = chl ^ (NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom));
            cycle();
        end
        arm = 1'b0; clr = 1'b0; wrt_smpl = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
